tx_frame_scheduler: RTL

Round-robin scheduler that shares the single UART transmitter among N_CH sensor channels. On each sample trigger (the synchronised 15-min tick) it snapshots which channels hold fresh ADC bytes. It then serialises them through the Tx one at a time, applying each channel's own baud/parity/stop/data-width configuration, and rotates the starting channel every round. It sits between the per-channel ADC capture registers and the Tx block.

---
 rtl/tx_frame_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tx_frame_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_CH capture channels.
// Each sample tick snapshots the fresh channels and sends them in rotating order, each with its own line config.
module tx_frame_scheduler #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned IDX_W   = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic [N_CH-1:0]       ch_valid,
  input  logic [8*N_CH-1:0]     ch_data,
  input  logic [6*N_CH-1:0]     ch_cfg,
  output logic [N_CH-1:0]       ch_ack,
  output logic [7:0]            tx_data,
  output logic [1:0]            tx_bd_sel,
  output logic [1:0]            tx_prty_sel,
  output logic                  tx_stop_sel,
  output logic                  tx_data_bit_sel,
  output logic                  tx_start,
  input  logic                  tx_busy,
  output logic [IDX_W-1:0]      tx_ch,
  output logic                  round_done,
  output logic                  overrun,
  output logic                  tx_err
);

  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W:0]   CNT_LAST = (IDX_W+1)'(N_CH - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, START, WAIT_BUSY, WAIT_DONE, NEXT, DONE
  } state_t;

  state_t            state;
  logic [N_CH-1:0]   pending;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W:0]    cnt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [TMR_W-1:0]  timer;

  logic [7:0]        data_arr [N_CH];
  logic [5:0]        cfg_arr  [N_CH];
  logic [IDX_W-1:0]  idx_inc;
  logic [IDX_W:0]    cnt_inc;
  logic              last_idx;

  // Flat channel buses viewed as per-channel arrays
  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign data_arr[i] = ch_data[8*i +: 8];
    assign cfg_arr[i]  = ch_cfg[6*i +: 6];
  end

  assign idx_inc  = IDX_W'(idx + 1'b1);
  assign cnt_inc  = (IDX_W+1)'(cnt + 1'b1);
  assign last_idx = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pending         <= '0;
      idx             <= '0;
      cnt             <= '0;
      rr_ptr          <= '0;
      timer           <= '0;
      ch_ack          <= '0;
      tx_data         <= '0;
      tx_bd_sel       <= '0;
      tx_prty_sel     <= '0;
      tx_stop_sel     <= 1'b0;
      tx_data_bit_sel <= 1'b0;
      tx_start        <= 1'b0;
      tx_ch           <= '0;
      round_done      <= 1'b0;
      overrun         <= 1'b0;
      tx_err          <= 1'b0;
    end else begin
      ch_ack     <= '0;
      tx_start   <= 1'b0;
      round_done <= 1'b0;

      // A tick outside IDLE (including DONE) is dropped but remembered
      if (sample_tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick) begin
            pending <= ch_valid;
            idx     <= rr_ptr;
            cnt     <= '0;
            state   <= SCAN;
          end
        end
        SCAN: begin
          if (pending[idx]) begin
            tx_data <= data_arr[idx];
            {tx_bd_sel, tx_prty_sel, tx_stop_sel, tx_data_bit_sel} <= cfg_arr[idx];
            tx_ch   <= idx;
            ch_ack  <= N_CH'(1'b1) << idx;
            state   <= START;
          end else begin
            // Empty slot skips straight on, costing one cycle
            idx   <= idx_inc;
            cnt   <= cnt_inc;
            state <= last_idx ? DONE : SCAN;
          end
        end
        START: begin
          tx_start <= 1'b1;
          timer    <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (timer == TMR_LAST) begin
            tx_err <= 1'b1;
            state  <= NEXT;
          end else begin
            timer <= TMR_W'(timer + 1'b1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= NEXT;
        end
        NEXT: begin
          pending[idx] <= 1'b0;
          idx          <= idx_inc;
          cnt          <= cnt_inc;
          state        <= last_idx ? DONE : SCAN;
        end
        DONE: begin
          round_done <= 1'b1;
          rr_ptr     <= IDX_W'(rr_ptr + 1'b1);
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
